// File: rtl/hilo_muldiv_unit.sv
//------------------------------------------------------------------------------
// hilo_muldiv_unit
//
// Execute-stage multiply/divide engine producing the 64-bit {hi, lo} result
// that travels down the pipeline to the hi/lo write port in WB.
//   MULT/MULTU : operands latched on accept, product registered in the single
//                MUL cycle, result visible in DONE (two cycles after accept).
//   DIV/DIVU   : restoring divider on operand magnitudes, one quotient bit per
//                cycle, MSB first; sign correction applied when the last bit
//                is produced. Divide-by-zero skips the iterations entirely.
//
// Ports
//   clk             : system clock, rising edge
//   rst             : asynchronous reset, active low
//   start           : launch an operation (only honoured in IDLE, no flush)
//   op              : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a           : rs operand (multiplicand / dividend)
//   src_b           : rt operand (multiplier / divisor)
//   flush           : abort the in-flight operation / squash the done pulse
//   busy            : high while an operation occupies the unit (stall)
//   done            : one-cycle pulse, hl_data valid
//   hl_data         : {hi, lo}; held until the next completed operation
//   hl_write_enable : same as done, drives the hi/lo write in WB
//------------------------------------------------------------------------------
module hilo_muldiv_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [63:0] hl_data,
  output logic        hl_write_enable
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  // Operand / datapath state
  logic             mul_signed_reg;  // MULT (signed) vs MULTU
  logic [31:0]      opa_reg;         // multiplicand, or dividend shifting out / quotient shifting in
  logic [31:0]      opb_reg;         // multiplier, or divisor magnitude
  logic [31:0]      rem_reg;         // partial remainder (always < divisor, fits 32 bits)
  logic [CNT_W-1:0] cnt_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic [63:0]      hl_data_reg;

  //--------------------------------------------------------------------------
  // Accept decode and operand conditioning
  //--------------------------------------------------------------------------
  logic        accept;
  logic        in_is_div;
  logic        in_div_signed;
  logic        in_div_zero;
  logic [31:0] a_load;
  logic [31:0] b_load;

  assign accept        = (state_reg == ST_IDLE) && start && !flush;
  assign in_is_div     = op[1];
  assign in_div_signed = op[1] && !op[0];
  assign in_div_zero   = op[1] && (src_b == 32'd0);

  // Signed divide works on magnitudes; 0x80000000 maps onto itself, which is
  // exactly the unsigned magnitude, so the most-negative case needs no trap.
  assign a_load = (in_div_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign b_load = (in_div_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;

  //--------------------------------------------------------------------------
  // Multiplier: extend to 64 bits according to signedness; the low 64 bits of
  // the 64x64 product are the exact 32x32 result in both cases.
  //--------------------------------------------------------------------------
  logic [63:0] mul_ext_a;
  logic [63:0] mul_ext_b;
  logic [63:0] product;

  assign mul_ext_a = {{32{mul_signed_reg & opa_reg[31]}}, opa_reg};
  assign mul_ext_b = {{32{mul_signed_reg & opb_reg[31]}}, opb_reg};
  assign product   = mul_ext_a * mul_ext_b;

  //--------------------------------------------------------------------------
  // Restoring divide step: shift the next dividend bit into a 33-bit partial
  // remainder and subtract the divisor; a clear sign bit means the quotient
  // bit is 1 and the difference is kept.
  //--------------------------------------------------------------------------
  logic [32:0] rem_shift;
  logic [32:0] rem_trial;
  logic        q_bit;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;

  assign rem_shift = {rem_reg, opa_reg[31]};
  assign rem_trial = rem_shift - {1'b0, opb_reg};
  assign q_bit     = ~rem_trial[32];
  assign rem_step  = q_bit ? rem_trial[31:0] : rem_shift[31:0];
  assign quo_step  = {opa_reg[30:0], q_bit};

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  assign quo_fixed = neg_q_reg ? (~quo_step + 32'd1) : quo_step;
  assign rem_fixed = neg_r_reg ? (~rem_step + 32'd1) : rem_step;

  //--------------------------------------------------------------------------
  // FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        busy = accept;
        if (accept) begin
          if (!in_is_div) begin
            state_next = ST_MUL;
          end else if (in_div_zero) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        busy       = 1'b1;
        state_next = flush ? ST_IDLE : ST_DONE;
      end
      ST_DIV: begin
        busy = 1'b1;
        if (flush) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == LAST_ITER) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = !flush;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_signed_reg <= 1'b0;
      opa_reg        <= 32'd0;
      opb_reg        <= 32'd0;
      rem_reg        <= 32'd0;
      cnt_reg        <= '0;
      neg_q_reg      <= 1'b0;
      neg_r_reg      <= 1'b0;
      hl_data_reg    <= 64'd0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            mul_signed_reg <= !op[0];
            opa_reg        <= a_load;
            opb_reg        <= b_load;
            rem_reg        <= 32'd0;
            cnt_reg        <= '0;
            neg_q_reg      <= in_div_signed && (src_a[31] ^ src_b[31]);
            neg_r_reg      <= in_div_signed && src_a[31];
            // Divide-by-zero result is fixed and known at accept time.
            if (in_div_zero) begin
              hl_data_reg <= {src_a, 32'hFFFF_FFFF};
            end
          end
        end
        ST_MUL: begin
          if (!flush) begin
            hl_data_reg <= product;
          end
        end
        ST_DIV: begin
          if (flush) begin
            cnt_reg <= '0;
          end else begin
            opa_reg <= quo_step;
            rem_reg <= rem_step;
            if (cnt_reg == LAST_ITER) begin
              cnt_reg     <= '0;
              hl_data_reg <= {rem_fixed, quo_fixed};
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign hl_data         = hl_data_reg;
  assign hl_write_enable = done;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
`timescale 1ns/1ps
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [63:0] hl_data;
  logic        hl_write_enable;

  hilo_muldiv_unit #(.DIV_CYCLES(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .op              (op),
    .src_a           (src_a),
    .src_b           (src_b),
    .flush           (flush),
    .busy            (busy),
    .done            (done),
    .hl_data         (hl_data),
    .hl_write_enable (hl_write_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] data;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic operators, independent of the datapath.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sbv;
    int     q;
    int     r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    model = 64'd0;
    case (o)
      2'd0: model = 64'(sa * sbv);
      2'd1: model = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) begin
          model = {a, 32'hFFFF_FFFF};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          model = {32'd0, 32'h8000_0000};
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          model = {r, q};
        end
      end
      default: begin
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else            model = {a % b, a / b};
      end
    endcase
  endfunction

  // Drive start for one cycle (cycle 0); returns at the negedge of cycle 1.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input logic [63:0] exp, input int lat,
                        input bit push);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    if (push) sbq.push_back('{tag, exp, lat});
    #1 check({tag, "_busy_accept"}, 64'(busy), 64'd1);
    @(negedge clk);
    // Scramble operands: the unit must have latched them already.
    start = 1'b0;
    op    = 2'($urandom);
    src_a = $urandom;
    src_b = $urandom;
  endtask

  // Called at the negedge of cycle 1; waits for done and scores the result.
  task automatic wait_result(input int bound);
    exp_t e;
    int   cyc;
    bit   seen;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= bound) begin
      if (done) begin
        seen = 1'b1;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_done: observed done=1 with empty scoreboard, required none");
        end else begin
          e = sbq.pop_front();
          check({e.tag, "_latency"}, 64'(cyc), 64'(e.lat));
          check({e.tag, "_data"}, hl_data, e.data);
          check({e.tag, "_we"}, 64'(hl_write_enable), 64'd1);
          check({e.tag, "_busy_done"}, 64'(busy), 64'd0);
          $display("txn %s: done at cycle %0d hl_data=%h", e.tag, cyc, hl_data);
          @(negedge clk);
          check({e.tag, "_pulse"}, 64'(done), 64'd0);
          check({e.tag, "_hold"}, hl_data, e.data);
        end
      end else begin
        check("busy_run", 64'(busy), 64'd1);
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL timeout: no done within %0d cycles, required done", bound);
      if (sbq.size() != 0) void'(sbq.pop_front());
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          rl;

    rst   = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'd0;
    src_a = 32'd0;
    src_b = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hl_data", hl_data, 64'd0);
    check("reset_we", 64'(hl_write_enable), 64'd0);
    rst = 1'b1;

    // Directed multiply / divide
    launch(2'd0, 32'hFFFF_FFFE, 32'd3, "mult_m2x3", 64'hFFFF_FFFF_FFFF_FFFA, 2, 1'b1);
    wait_result(40);
    launch(2'd1, 32'hFFFF_FFFE, 32'd3, "multu_fffffffex3", 64'h0000_0002_FFFF_FFFA, 2, 1'b1);
    wait_result(40);
    launch(2'd3, 32'd100, 32'd7, "divu_100_7", {32'd2, 32'd14}, 33, 1'b1);
    wait_result(40);
    launch(2'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2", {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b1);
    wait_result(40);
    launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1", {32'd0, 32'h8000_0000}, 33, 1'b1);
    wait_result(40);
    launch(2'd2, 32'd5, 32'd0, "div_5_0", {32'd5, 32'hFFFF_FFFF}, 1, 1'b1);
    wait_result(40);
    launch(2'd3, 32'h1234_5678, 32'd0, "divu_x_0", {32'h1234_5678, 32'hFFFF_FFFF}, 1, 1'b1);
    wait_result(40);

    // Random operations against the reference model
    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : (($urandom & 1) != 0 ? $urandom : $urandom_range(1, 300));
      rl = (ro[1] == 1'b0) ? 2 : ((rb == 32'd0) ? 1 : 33);
      launch(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro), model(ro, ra, rb), rl, 1'b1);
      wait_result(40);
    end

    // Flush while in DONE squashes the pulse
    launch(2'd1, 32'd3, 32'd4, "multu_flush_done", 64'd0, 0, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_done_done", 64'(done), 64'd0);
    check("flush_done_we", 64'(hl_write_enable), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_done_after_busy", 64'(busy), 64'd0);
    $display("txn flush_in_done: pulse suppressed");

    // start together with flush in IDLE is ignored
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    op    = 2'd0;
    src_a = 32'd2;
    src_b = 32'd2;
    #1 check("flush_idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_idle_c1_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("flush_idle_c2_done", 64'(done), 64'd0);
    $display("txn flush_in_idle: start ignored");

    // DIVU flushed at cycle 10, then MULTU 6*7 launched at cycle 12
    launch(2'd3, 32'd1000, 32'd3, "divu_flushed", 64'd0, 0, 1'b0);
    for (int c = 1; c < 10; c++) begin
      check("flush_div_busy", 64'(busy), 64'd1);
      check("flush_div_nodone", 64'(done), 64'd0);
      @(negedge clk);
    end
    check("flush_div_c10_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    #1 check("flush_div_c10_done", 64'(done), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_div_c11_busy", 64'(busy), 64'd0);
    check("flush_div_c11_done", 64'(done), 64'd0);
    $display("txn divu_flushed: aborted at cycle 10");
    launch(2'd1, 32'd6, 32'd7, "multu_6x7", 64'd42, 2, 1'b1);
    wait_result(10);

    // Asynchronous reset in the middle of a DIV
    launch(2'd2, 32'hFFFF_FF00, 32'd5, "div_reset", 64'd0, 0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hl_data", hl_data, 64'd0);
    check("arst_we", 64'(hl_write_enable), 64'd0);
    @(negedge clk);
    check("arst_hold_busy", 64'(busy), 64'd0);
    check("arst_hold_hl_data", hl_data, 64'd0);
    rst = 1'b1;
    $display("txn div_reset: aborted by asynchronous reset at cycle 5");
    launch(2'd3, 32'd9, 32'd3, "divu_9_3", {32'd0, 32'd3}, 33, 1'b1);
    wait_result(40);

    check("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage multiply/divide engine that produces the 64-bit {hi, lo} result.
- The result travels down the pipeline as hl_data / hl_write_enable and reaches the register file's hi/lo write port in WB.
- MULT/MULTU: 2-cycle registered multiplier. DIV/DIVU: 32-iteration restoring divider.
- Holds the pipeline via busy until the result is valid.

Parameters:
- DIV_CYCLES, 32, number of divider iterations; fixed at operand width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  input  32  rs operand (dividend / multiplicand).
- src_b  input  32  rt operand (divisor / multiplier).
- flush  input  1  exception/flush; aborts the in-flight op.
- busy  output  1  high while an op is in progress; the pipeline stalls on it.
- done  output  1  one-cycle pulse; the result is valid this cycle.
- hl_data  output  64  {hi, lo} result.
- hl_write_enable  output  1  equals done; drives the hi/lo write in WB.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, hl_write_enable = 0, hl_data = 64'h0.
  - Iteration counter = 0.
- Operands and op are latched on the cycle start is accepted (IDLE and start = 1). Inputs are ignored afterwards.
- States: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL when start and op[1] = 0.
  - IDLE -> DIV when start, op[1] = 1 and src_b != 0.
  - IDLE -> DONE when start, op[1] = 1 and src_b == 0 (fast path).
  - MUL -> DONE after 1 cycle. The product is registered in the MUL cycle.
  - DIV -> DONE when the counter reaches DIV_CYCLES-1.
  - DONE -> IDLE unconditionally.
- busy = 1 in MUL and DIV, and in the accepting cycle (combinational from start in IDLE). busy = 0 in DONE and IDLE.
- done = 1 only in DONE. hl_data holds its value after DONE until the next DONE.
- Latency (start accepted at cycle 0):
  - Multiply: done at cycle 2.
  - Divide: done at cycle 33.
  - Divide-by-zero: done at cycle 1.
- Multiply:
  - MULT is a signed 32x32 -> 64 product; MULTU is unsigned.
  - hl_data = product: hi = [63:32], lo = [31:0].
- Divide:
  - Operates on magnitudes (|a|, |b| for DIV; raw values for DIVU).
  - One quotient bit per cycle, MSB first, with a 33-bit partial remainder.
  - DIV sign fix at DONE:
    - quotient negated if a[31] ^ b[31];
    - remainder negated if a[31] (remainder takes the dividend's sign).
  - hl_data = {remainder, quotient}.
- Boundary cases:
  - Divide-by-zero (DIV or DIVU): quotient = 32'hFFFFFFFF, remainder = src_a.
  - DIV 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. This must fall out of the magnitude path without trapping.
- flush:
  - In MUL or DIV: return to IDLE next cycle; no done, no hl_write_enable.
  - In DONE: suppresses done / hl_write_enable for that cycle.
  - In IDLE with start: start is ignored.
- start while busy is ignored; upstream must hold the instruction while busy.
- Asynchronous reset mid-operation aborts immediately, with all outputs at reset values.

Test Plan:
- MULT src_a = 0xFFFFFFFE (-2), src_b = 3 -> done at cycle 2, hl_data = 64'hFFFFFFFF_FFFFFFFA. MULTU with the same operands -> 64'h00000002_FFFFFFFA.
- DIVU 100 / 7 -> done at cycle 33, hl_data = {32'd2, 32'd14}. busy high cycles 0-32 and low at 33.
- DIV -7 / 2 -> hl_data = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- DIV 5 / 0 -> done at cycle 1, hl_data = {32'h5, 32'hFFFFFFFF}.
- DIVU started, flush at cycle 10 -> busy low at cycle 11, no done pulse. A new MULTU 6 * 7 started at cycle 12 -> done at 14, hl_data = 64'd42.
- rst driven low asynchronously at cycle 5 of a DIV -> busy, done and hl_data = 0 immediately. After rst release, a fresh DIVU 9 / 3 completes normally with {0, 3}.
